// File: rtl/mul_share_pkg.sv
// ----------------------------------------------------------------------------
// mul_share_pkg
// Shared definitions for the shared-multiplier arbiter slice.
//   NREQ_MAX : largest supported requester count.
//   ID_W     : width of a stored requester id. It is sized for NREQ_MAX so that
//              one tag type serves every legal NREQ; the top trims it to
//              $clog2(NREQ) at the resp_id port.
//   tag_t    : one tag-pipeline stage {valid, owner id}.
//   rr_next  : round-robin successor of an index, modulo the requester count.
// ----------------------------------------------------------------------------
package mul_share_pkg;

    localparam int NREQ_MAX = 8;
    localparam int ID_W     = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{v: 1'b0, id: {ID_W{1'b0}}};

    // Index following idx in a ring of nreq requesters.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx,
                                                input int              nreq);
        int nx;
        nx = int'(idx) + 1;
        if (nx >= nreq) begin
            nx = 0;
        end else begin
            nx = nx;
        end
        return nx[ID_W-1:0];
    endfunction

endpackage : mul_share_pkg

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter over NREQ requesters.
//   valid     : request vector, one bit per requester.
//   ptr       : highest-priority index for this cycle (0..NREQ-1).
//   advance   : when low, no grant is issued (pipeline stalled or in reset).
//   grant     : one-hot grant, all zero when nothing is granted.
//   grant_idx : encoded index of the granted requester (0 when none).
//   grant_any : a grant was issued this cycle.
// The search starts at ptr and wraps modulo NREQ. The vector is doubled and
// shifted right by ptr so that bit j of the window is requester (ptr+j)%NREQ;
// the lowest set bit of the window is the winner.
// ----------------------------------------------------------------------------
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    logic [2*NREQ-1:0] window_s;
    logic              hit_s;
    int                pos_s;
    int                sel_s;

    // Rotate the request vector so the search always starts at bit 0.
    always_comb begin
        window_s = {valid, valid} >> ptr;
        hit_s    = |valid;
    end

    // Lowest set bit of the rotated window, mapped back to a requester index.
    always_comb begin
        pos_s = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (window_s[j]) begin
                pos_s = j;
            end else begin
                pos_s = pos_s;
            end
        end
        sel_s = int'(ptr) + pos_s;
        if (sel_s >= NREQ) begin
            sel_s = sel_s - NREQ;
        end else begin
            sel_s = sel_s;
        end
    end

    // Gate the winner with advance and produce the one-hot and encoded forms.
    always_comb begin
        grant_any = advance & hit_s;
        grant     = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = grant_any & (i == sel_s);
        end
        if (grant_any) begin
            grant_idx = sel_s[ID_W-1:0];
        end else begin
            grant_idx = {ID_W{1'b0}};
        end
    end

endmodule : rr_arbiter

// File: rtl/mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// mul_share_arbiter
// Shares one fixed-latency, enable-stalled signed multiplier among NREQ
// requesters. Requests are granted round-robin, one per cycle; a tag pipeline
// of LAT stages follows each product through the multiplier so the result can
// be returned on a single backpressured response port in issue order.
//
// Ports
//   clk        : rising-edge clock.
//   reset      : asynchronous active-low reset; flushes all in-flight tags.
//   req_valid  : per-requester request pending.
//   req_a/b    : per-requester signed operands, slice i belongs to requester i.
//   req_ready  : one-hot grant; accept = req_valid[i] & req_ready[i].
//   mul_a/b    : operands presented to the multiplier (0 with no grant).
//   mul_en     : multiplier pipeline enable, low only while a response stalls.
//   mul_result : multiplier product, LAT enabled edges after operand capture.
//   resp_valid : response available.
//   resp_id    : requester owning the response.
//   resp_data  : signed 2W product, passed through from mul_result.
//   resp_ready : consumer accepts the response.
//   busy       : some tag stage holds a live product.
// ----------------------------------------------------------------------------
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  W     = 32,
    parameter int  LAT   = 3,
    localparam int RID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_en,
    input  logic [2*W-1:0]    mul_result,
    output logic              resp_valid,
    output logic [RID_W-1:0]  resp_id,
    output logic [2*W-1:0]    resp_data,
    input  logic              resp_ready,
    output logic              busy
);

    logic            stall_s;
    logic            advance_s;
    logic [NREQ-1:0] grant_s;
    logic [ID_W-1:0] grant_idx_s;
    logic            grant_any_s;
    logic [W-1:0]    mul_a_s;
    logic [W-1:0]    mul_b_s;
    logic            busy_s;
    logic [ID_W-1:0] ptr_r;
    tag_t            tag_r [LAT];

    // Only a live, unaccepted response can stall; a bubble at the output
    // never holds the pipeline.
    always_comb begin
        stall_s   = tag_r[LAT-1].v & ~resp_ready;
        // reset gates the grant so nothing looks accepted while flushing
        advance_s = reset & ~stall_s;
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (ptr_r),
        .advance   (advance_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    // Operand mux: AND-OR select on the one-hot grant, zero when idle.
    always_comb begin
        mul_a_s = {W{1'b0}};
        mul_b_s = {W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            mul_a_s = mul_a_s | (req_a[i*W +: W] & {W{grant_s[i]}});
            mul_b_s = mul_b_s | (req_b[i*W +: W] & {W{grant_s[i]}});
        end
    end

    // Round-robin pointer: moves past the winner on every accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {ID_W{1'b0}};
        end else if (grant_any_s) begin
            ptr_r <= rr_next(grant_idx_s, NREQ);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag pipeline: advances in lockstep with the multiplier, holds on stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LAT; s++) begin
                tag_r[s] <= TAG_IDLE;
            end
        end else if (!stall_s) begin
            // grant_any implies req_valid of the winner, so it is the accept
            tag_r[0] <= '{v: grant_any_s, id: grant_idx_s};
            for (int s = 1; s < LAT; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end else begin
            for (int s = 0; s < LAT; s++) begin
                tag_r[s] <= tag_r[s];
            end
        end
    end

    // Occupancy flag over all tag stages.
    always_comb begin
        busy_s = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            busy_s = busy_s | tag_r[s].v;
        end
    end

    assign req_ready  = grant_s;
    assign mul_a      = mul_a_s;
    assign mul_b      = mul_b_s;
    assign mul_en     = ~stall_s;
    assign resp_valid = tag_r[LAT-1].v;
    assign resp_id    = tag_r[LAT-1].id[RID_W-1:0];
    // the multiplier output is frozen while mul_en is low, so data holds too
    assign resp_data  = mul_result;
    assign busy       = busy_s;

endmodule : mul_share_arbiter

// File: tb/tb_mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mul_share_arbiter
// Directed and random stimulus for mul_share_arbiter. A behavioural multiplier
// (LAT-stage, enable-stalled) sits on the datapath side. The reference model
// is a queue of in-flight {owner, product, issue-time} items and a
// round-robin pointer; an item is due at the response port once LAT-1
// enabled cycles have passed since its issue.
// ----------------------------------------------------------------------------
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 3;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_en;
    logic [2*W-1:0]    mul_result;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [2*W-1:0]    resp_data;
    logic              resp_ready;
    logic              busy;

    mul_share_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_en     (mul_en),
        .mul_result (mul_result),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural enable-stalled signed multiplier.
    logic [63:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            mpipe[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[LAT-1];

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          k;
    } item_t;

    item_t             q[$];
    int                ptr_m;
    int                en_cnt;
    int                vecs;
    int                errs;
    logic signed [31:0] opa [NREQ];
    logic signed [31:0] opb [NREQ];
    int                gnt_log[$];
    int                dlv_id[$];
    logic [63:0]       dlv_data[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model at negedge, then
    // advance the model across the rising edge.
    task automatic cycle(input logic [NREQ-1:0] vld, input logic rr);
        int              g;
        int              c;
        logic            exp_rv;
        logic            stall;
        logic [NREQ-1:0] exp_rdy;
        logic [31:0]     ea;
        logic [31:0]     eb;
        req_valid  = vld;
        resp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
        exp_rv = 1'b0;
        if (q.size() > 0) exp_rv = ((en_cnt - q[0].k) == (LAT - 1));
        stall = exp_rv && !rr;
        g = -1;
        if (!stall) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (ptr_m + k) % NREQ;
                if (g < 0 && vld[c]) g = c;
            end
        end
        exp_rdy = '0;
        ea = '0;
        eb = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ea = opa[g];
            eb = opb[g];
        end
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mul_en", 64'(mul_en), 64'(!stall));
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        chk("mul_a", 64'(mul_a), 64'(ea));
        chk("mul_b", 64'(mul_b), 64'(eb));
        if (exp_rv) begin
            chk("resp_id", 64'(resp_id), 64'(q[0].id));
            chk("resp_data", resp_data, q[0].prod);
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i] && vld[i]) gnt_log.push_back(i);
        if (resp_valid && rr) begin
            dlv_id.push_back(int'(resp_id));
            dlv_data.push_back(resp_data);
        end
        @(posedge clk);
        if (exp_rv && rr) void'(q.pop_front());
        if (!stall) en_cnt++;
        if (g >= 0) begin
            q.push_back('{g, 64'(longint'(opa[g]) * longint'(opb[g])), en_cnt});
            ptr_m = (g + 1) % NREQ;
        end
        #1;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        dlv_id.delete();
        dlv_data.delete();
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        ptr_m  = 0;
        en_cnt = 0;
        clear_logs();
    endtask

    task automatic drain();
        repeat (LAT + 2) cycle(4'b0000, 1'b1);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        ptr_m = 0;
        en_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 32'sd0;
            opb[i] = 32'sd0;
        end
        req_a = '0;
        req_b = '0;
        // Reset state, with requests pending and the consumer stalled.
        reset      = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mul_en", 64'(mul_en), 64'd1);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        do_reset();

        // 1: single request.
        opa[0] = 32'sd553524;
        opb[0] = 32'sd840;
        cycle(4'b0001, 1'b1);
        drain();
        chk("t1_count", 64'(dlv_id.size()), 64'd1);
        if (dlv_id.size() >= 1) begin
            chk("t1_id", 64'(dlv_id[0]), 64'd0);
            chk("t1_data", dlv_data[0], 64'd464960160);
        end

        // 2: all four valid from reset; each drops once served.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 32'(i + 1);
            opb[i] = 32'(i + 2);
        end
        cycle(4'b1111, 1'b1);
        cycle(4'b1110, 1'b1);
        cycle(4'b1100, 1'b1);
        cycle(4'b1000, 1'b1);
        drain();
        chk("t2_count", 64'(dlv_id.size()), 64'd4);
        if (dlv_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_grant", 64'(gnt_log[i]), 64'(i));
                chk("t2_id", 64'(dlv_id[i]), 64'(i));
                chk("t2_data", dlv_data[i], 64'((i + 1) * (i + 2)));
            end
        end

        // 3: signed operands on requesters 1 and 3.
        clear_logs();
        opa[1] = -32'sd259;
        opb[1] = -32'sd259;
        opa[3] = 32'sd553524;
        opb[3] = -32'sd259;
        cycle(4'b1010, 1'b1);
        cycle(4'b1000, 1'b1);
        drain();
        chk("t3_count", 64'(dlv_id.size()), 64'd2);
        if (dlv_id.size() >= 2) begin
            chk("t3_id0", 64'(dlv_id[0]), 64'd1);
            chk("t3_data0", dlv_data[0], 64'd67081);
            chk("t3_id1", 64'(dlv_id[1]), 64'd3);
            chk("t3_data1", dlv_data[1], -64'sd143362716);
        end

        // 4: backpressure for 5 cycles once the first response shows.
        clear_logs();
        opa[0] = 32'sd7;  opb[0] = -32'sd3;
        opa[1] = 32'sd11; opb[1] = 32'sd13;
        opa[2] = -32'sd5; opb[2] = -32'sd9;
        cycle(4'b0001, 1'b1);
        cycle(4'b0010, 1'b1);
        cycle(4'b0100, 1'b1);
        repeat (5) cycle(4'b1111, 1'b0);
        repeat (6) cycle(4'b0000, 1'b1);
        chk("t4_count", 64'(dlv_id.size()), 64'd3);
        if (dlv_id.size() >= 3) begin
            chk("t4_id0", 64'(dlv_id[0]), 64'd0);
            chk("t4_id1", 64'(dlv_id[1]), 64'd1);
            chk("t4_id2", 64'(dlv_id[2]), 64'd2);
            chk("t4_data2", dlv_data[2], 64'd45);
        end

        // 5: fairness between requesters 0 and 2.
        do_reset();
        repeat (8) cycle(4'b0101, 1'b1);
        drain();
        chk("t5_count", 64'(gnt_log.size()), 64'd8);
        if (gnt_log.size() >= 8) begin
            for (int j = 0; j < 8; j++) chk("t5_order", 64'(gnt_log[j]), 64'((j % 2) * 2));
        end

        // 6: reset with two products in flight.
        do_reset();
        opa[1] = 32'sd100; opb[1] = 32'sd3;
        opa[2] = 32'sd200; opb[2] = 32'sd4;
        cycle(4'b0010, 1'b1);
        cycle(4'b0100, 1'b1);
        #2;
        req_valid = 4'b1111;
        reset     = 1'b0;
        #1;
        chk("t6_resp_valid", 64'(resp_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_req_ready", 64'(req_ready), 64'd0);
        chk("t6_mul_en", 64'(mul_en), 64'd1);
        q.delete();
        ptr_m  = 0;
        en_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        repeat (2 * LAT) cycle(4'b0000, 1'b0);
        chk("t6_stale", 64'(dlv_id.size()), 64'd0);
        opa[3] = 32'sd9; opb[3] = 32'sd9;
        cycle(4'b1010, 1'b1);
        drain();
        chk("t6_regrant", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd1);

        // Random traffic with random backpressure.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(1) == 0) begin
                    opa[i] = $urandom;
                    opb[i] = $urandom;
                end else begin
                    opa[i] = 32'($urandom_range(600)) - 32'sd300;
                    opb[i] = 32'($urandom_range(600)) - 32'sd300;
                end
            end
            cycle(4'($urandom), ($urandom_range(3) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_mul_share_arbiter
